// File: rtl/xnor_cmp_pipe.sv
// xnor_cmp_pipe: two-stage bitwise XNOR comparator with popcount score,
// threshold match, equality flag and optional handshake statistics.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/a/b operand
// handshake; out_valid/out_ready/y/score/match/full_eq result handshake;
// stats_clr, txn_cnt, eq_cnt statistics (live only with XNOR_CMP_STATS_EN).
module xnor_cmp_pipe #(
  parameter int WIDTH  = 8,
  parameter int THRESH = WIDTH,
  localparam int SW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [SW-1:0]    score,
  output logic             match,
  output logic             full_eq,
  input  logic             stats_clr,
  output logic [15:0]      txn_cnt,
  output logic [15:0]      eq_cnt
);

  localparam logic [31:0] THR = 32'(THRESH);

  logic             stall;
  logic             v1;
  logic [WIDTH-1:0] y1;
  logic [SW-1:0]    pc;
  logic             mt;
  logic             eq1;

  // A full output register that is not taken freezes the whole pipe.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      y1 <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      if (in_valid) begin
        y1 <= ~(a ^ b);
      end
    end
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + SW'(y1[i]);
    end
  end

  // THRESH = 0 makes this constant 1.
  assign mt  = 32'(pc) >= THR;
  assign eq1 = &y1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      score     <= '0;
      match     <= 1'b0;
      full_eq   <= 1'b0;
    end else if (!stall) begin
      out_valid <= v1;
      if (v1) begin
        y       <= y1;
        score   <= pc;
        match   <= mt;
        full_eq <= eq1;
      end
    end
  end

`ifdef XNOR_CMP_STATS_EN
  logic fire;

  assign fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      txn_cnt <= '0;
      eq_cnt  <= '0;
    end else if (fire) begin
      if (txn_cnt != 16'hFFFF) begin
        txn_cnt <= txn_cnt + 16'd1;
      end
      if (full_eq && eq_cnt != 16'hFFFF) begin
        eq_cnt <= eq_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign txn_cnt          = '0;
  assign eq_cnt           = '0;
`endif

endmodule

// File: tb/tb_xnor_cmp_pipe.sv
// tb_xnor_cmp_pipe: randomized and directed checks of xnor_cmp_pipe
// (WIDTH=8, THRESH=6) against a queue-based reference model.
module tb_xnor_cmp_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  y;
  logic [3:0]  score;
  logic        match;
  logic        full_eq;
  logic        stats_clr;
  logic [15:0] txn_cnt;
  logic [15:0] eq_cnt;

  xnor_cmp_pipe #(.WIDTH(8), .THRESH(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .score(score), .match(match), .full_eq(full_eq),
    .stats_clr(stats_clr), .txn_cnt(txn_cnt), .eq_cnt(eq_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [13:0] exp_q[$];
  logic [15:0] txn_m = 16'h0;
  logic [15:0] eq_m  = 16'h0;

  logic        c_fire, c_acc, c_irdy, c_ov;
  logic [13:0] c_obs, c_exp;

  function automatic logic [13:0] ref_res(input logic [7:0] ra,
                                          input logic [7:0] rb);
    logic [7:0] yy;
    int n;
    logic m, f;
    yy = ~(ra ^ rb);
    n  = $countones(yy);
    m  = n >= 6;
    f  = ra == rb;
    return {yy, 4'(n), m, f};
  endfunction

  task automatic cycle(input logic iv, input logic [7:0] ia,
                       input logic [7:0] ib, input logic ordy,
                       input logic sclr);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    stats_clr = sclr;
    #1;
    c_irdy = in_ready;
    c_ov   = out_valid;
    c_acc  = iv && in_ready;
    c_fire = out_valid && ordy;
    c_obs  = {y, score, match, full_eq};
    c_exp  = 'x;
    if (c_fire && exp_q.size() > 0) c_exp = exp_q.pop_front();
    if (c_acc) exp_q.push_back(ref_res(ia, ib));
`ifdef XNOR_CMP_STATS_EN
    if (c_fire) begin
      if (txn_m != 16'hFFFF) txn_m = txn_m + 16'd1;
      if (c_exp[0] === 1'b1 && eq_m != 16'hFFFF) eq_m = eq_m + 16'd1;
    end
    if (sclr) begin
      txn_m = 16'h0;
      eq_m  = 16'h0;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic iv, input logic ordy);
    rst       = 1'b1;
    in_valid  = iv;
    out_ready = ordy;
    stats_clr = 1'b0;
    a         = 8'h3C;
    b         = 8'h3C;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    txn_m = 16'h0;
    eq_m  = 16'h0;
  endtask

  task automatic test_reset;
    do_reset(1'b1, 1'b0);
    n_total++;
    if (out_valid !== 1'b0)
      $display("FAIL rst_out_valid got %0b want 0", out_valid);
    else n_pass++;
    n_total++;
    if (y !== 8'h00) $display("FAIL rst_y got %h want 00", y);
    else n_pass++;
    n_total++;
    if (score !== 4'd0) $display("FAIL rst_score got %0d want 0", score);
    else n_pass++;
    n_total++;
    if (match !== 1'b0) $display("FAIL rst_match got %0b want 0", match);
    else n_pass++;
    n_total++;
    if (full_eq !== 1'b0)
      $display("FAIL rst_full_eq got %0b want 0", full_eq);
    else n_pass++;
    n_total++;
    if (txn_cnt !== 16'h0)
      $display("FAIL rst_txn_cnt got %h want 0", txn_cnt);
    else n_pass++;
    n_total++;
    if (eq_cnt !== 16'h0) $display("FAIL rst_eq_cnt got %h want 0", eq_cnt);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1)
      $display("FAIL rst_in_ready got %0b want 1", in_ready);
    else n_pass++;
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    n_total++;
    if (out_valid !== 1'b0)
      $display("FAIL rst_no_ghost got %0b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_directed;
    logic [7:0] ta[4] = '{8'h00, 8'hA5, 8'hF0, 8'hF0};
    logic [7:0] tb[4] = '{8'h00, 8'h5A, 8'hF3, 8'hF7};
    logic [7:0] ty[4] = '{8'hFF, 8'h00, 8'hFC, 8'hF8};
    int         ts[4] = '{8, 0, 6, 5};
    logic       tm[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       tf[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, ta[i], tb[i], 1'b1, 1'b0);
      n_total++;
      if (out_valid !== 1'b0)
        $display("FAIL dir%0d_early_valid got %0b want 0", i, out_valid);
      else n_pass++;
      cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      n_total++;
      if (out_valid !== 1'b1)
        $display("FAIL dir%0d_latency got %0b want 1", i, out_valid);
      else n_pass++;
      n_total++;
      if (y !== ty[i] || score !== 4'(ts[i]) || match !== tm[i] ||
          full_eq !== tf[i])
        $display("FAIL dir%0d_result got y=%h s=%0d m=%0b f=%0b want y=%h s=%0d m=%0b f=%0b",
                 i, y, score, match, full_eq, ty[i], ts[i], tm[i], tf[i]);
      else n_pass++;
      cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      n_total++;
      if (c_fire !== 1'b1 || c_obs !== c_exp)
        $display("FAIL dir%0d_model got %h want %h", i, c_obs, c_exp);
      else n_pass++;
      n_total++;
      if (out_valid !== 1'b0)
        $display("FAIL dir%0d_single got %0b want 0", i, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  pa[3];
    logic [7:0]  pb[3];
    logic [13:0] held;
    logic        seen_ov = 1'b0;
    logic        ordy;
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    held = '0;
    for (int i = 0; i < 3; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
    while ((sent < 3 || got < 3) && cyc < 40) begin
      if (out_valid) seen_ov = 1'b1;
      ordy = !(seen_ov && stall_cnt < 4);
      if (!ordy) stall_cnt++;
      cycle(sent < 3, pa[sent % 3], pb[sent % 3], ordy, 1'b0);
      if (c_acc) sent++;
      if (!ordy) begin
        n_total++;
        if (c_irdy !== 1'b0 || c_ov !== 1'b1)
          $display("FAIL b2b_stall_ready got rdy=%0b ov=%0b want 0/1",
                   c_irdy, c_ov);
        else n_pass++;
        if (stall_cnt > 1) begin
          n_total++;
          if (c_obs !== held)
            $display("FAIL b2b_stable got %h want %h", c_obs, held);
          else n_pass++;
        end
        held = c_obs;
      end
      if (c_fire) begin
        got++;
        n_total++;
        if (c_obs !== c_exp)
          $display("FAIL b2b_order%0d got %h want %h", got, c_obs, c_exp);
        else n_pass++;
      end
      cyc++;
    end
    n_total++;
    if (got != 3 || sent != 3 || stall_cnt != 4)
      $display("FAIL b2b_count got %0d/%0d stalls %0d want 3/3 stalls 4",
               got, sent, stall_cnt);
    else n_pass++;
    n_total++;
    if (out_valid !== 1'b0 || exp_q.size() != 0)
      $display("FAIL b2b_no_dup got ov=%0b q=%0d want 0/0",
               out_valid, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_random;
    logic [7:0]  ra, rb;
    logic        iv, ordy;
    logic        prev_stall = 1'b0;
    logic [13:0] prev_obs;
    int          mode;
    int          drain = 0;
    prev_obs = '0;
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 3);
      ra   = 8'($urandom);
      if (mode == 0) rb = ra;
      else if (mode == 1) rb = ra ^ (8'h01 << $urandom_range(0, 7));
      else rb = 8'($urandom);
      iv   = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 3) != 0;
      cycle(iv, ra, rb, ordy, 1'b0);
      n_total++;
      if (c_irdy !== !(c_ov && !ordy))
        $display("FAIL rnd_in_ready cyc%0d got %0b want %0b",
                 i, c_irdy, !(c_ov && !ordy));
      else n_pass++;
      if (prev_stall) begin
        n_total++;
        if (c_ov !== 1'b1 || c_obs !== prev_obs)
          $display("FAIL rnd_hold cyc%0d got %h want %h", i, c_obs, prev_obs);
        else n_pass++;
      end
      if (c_fire) begin
        n_total++;
        if (c_obs !== c_exp)
          $display("FAIL rnd_result cyc%0d got %h want %h", i, c_obs, c_exp);
        else n_pass++;
      end
      prev_stall = c_ov && !ordy;
      prev_obs   = c_obs;
    end
    while ((exp_q.size() > 0 || out_valid) && drain < 10) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      if (c_fire) begin
        n_total++;
        if (c_obs !== c_exp)
          $display("FAIL rnd_drain got %h want %h", c_obs, c_exp);
        else n_pass++;
      end
      drain++;
    end
    n_total++;
    if (exp_q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL rnd_drained got q=%0d ov=%0b want 0/0",
               exp_q.size(), out_valid);
    else n_pass++;
    n_total++;
    if (txn_cnt !== txn_m || eq_cnt !== eq_m)
      $display("FAIL rnd_stats got %h/%h want %h/%h",
               txn_cnt, eq_cnt, txn_m, eq_m);
    else n_pass++;
  endtask

  task automatic test_reset_midflight;
    cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 8'h33, 1'b0, 1'b0);
    n_total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL mid_full got ov=%0b rdy=%0b want 1/0",
               out_valid, in_ready);
    else n_pass++;
    do_reset(1'b1, 1'b0);
    n_total++;
    if (out_valid !== 1'b0 || txn_cnt !== 16'h0 || eq_cnt !== 16'h0)
      $display("FAIL mid_rst got ov=%0b txn=%h eq=%h want 0/0/0",
               out_valid, txn_cnt, eq_cnt);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      n_total++;
      if (out_valid !== 1'b0)
        $display("FAIL mid_stale%0d got %0b want 0", i, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_stats;
    logic [7:0] ra;
    int         n;
`ifdef XNOR_CMP_STATS_EN
    n = 65540;
`else
    n = 30;
`endif
    for (int i = 0; i < n; i++) begin
      ra = 8'($urandom);
      cycle(1'b1, ra, ra, 1'b1, 1'b0);
    end
    n_total++;
    if (txn_cnt !== txn_m || eq_cnt !== eq_m)
      $display("FAIL st_sat got %h/%h want %h/%h",
               txn_cnt, eq_cnt, txn_m, eq_m);
    else n_pass++;
`ifdef XNOR_CMP_STATS_EN
    n_total++;
    if (txn_cnt !== 16'hFFFF || eq_cnt !== 16'hFFFF)
      $display("FAIL st_sat_abs got %h/%h want ffff/ffff", txn_cnt, eq_cnt);
    else n_pass++;
`endif
    ra = 8'($urandom);
    cycle(1'b1, ra, ra, 1'b1, 1'b1);
    n_total++;
    if (c_fire !== 1'b1 || txn_cnt !== 16'h0 || eq_cnt !== 16'h0)
      $display("FAIL st_clr got fire=%0b %h/%h want 1 0/0",
               c_fire, txn_cnt, eq_cnt);
    else n_pass++;
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    n_total++;
    if (txn_cnt !== txn_m || eq_cnt !== eq_m)
      $display("FAIL st_after_clr got %h/%h want %h/%h",
               txn_cnt, eq_cnt, txn_m, eq_m);
    else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    stats_clr = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
